// File: rtl/iob_fifo_pkg.sv
// Shared helpers for the synchronous FIFO and its dual-port RAM.
// Holds the depth helper and the decoded request type used by iob_fifo_sync.
package iob_fifo_pkg;

  function automatic int unsigned fifo_depth(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

  typedef struct packed {
    logic push;
    logic pop;
  } fifo_req_t;

endpackage

// File: rtl/iob_dp_ram_be.sv
// Dual-port RAM with per-byte write enables and registered, read-first outputs.
// Each port is independent; a disabled port holds its last output word.
module iob_dp_ram_be
  import iob_fifo_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic                clk,
  input  logic                en_a,
  input  logic [DATA_W/8-1:0] we_a,
  input  logic [ADDR_W-1:0]   addr_a,
  input  logic [DATA_W-1:0]   din_a,
  output logic [DATA_W-1:0]   dout_a,
  input  logic                en_b,
  input  logic [DATA_W/8-1:0] we_b,
  input  logic [ADDR_W-1:0]   addr_b,
  input  logic [DATA_W-1:0]   din_b,
  output logic [DATA_W-1:0]   dout_b
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_W);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset; contents are only meaningful once written.
  always_ff @(posedge clk) begin
    if (en_a) begin
      dout_a <= mem_q[addr_a];
      for (int b = 0; b < DATA_W / 8; b++) begin
        if (we_a[b]) mem_q[addr_a][b*8 +: 8] <= din_a[b*8 +: 8];
      end
    end
    if (en_b) begin
      dout_b <= mem_q[addr_b];
      for (int b = 0; b < DATA_W / 8; b++) begin
        if (we_b[b]) mem_q[addr_b][b*8 +: 8] <= din_b[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/iob_fifo_sync.sv
// Synchronous FIFO front end for iob_dp_ram_be: pointers, level, flags, error pulses.
// Define IOB_FIFO_FWFT_EN for first-word-fall-through; default is 1-cycle read latency.
module iob_fifo_sync
  import iob_fifo_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              w_en,
  input  logic [DATA_W-1:0] w_data,
  output logic              w_full,
  output logic              w_err,
  input  logic              r_en,
  output logic [DATA_W-1:0] r_data,
  output logic              r_valid,
  output logic              r_empty,
  output logic              r_err,
  output logic [ADDR_W:0]   level
);

  localparam logic [ADDR_W:0]   LVL_FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   LVL_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  fifo_req_t         req;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              full_q, empty_q, empty_d;
  logic              w_err_q, r_err_q;
  logic              ram_rd_en;
  logic [DATA_W-1:0] unused_dout_a;

`ifdef IOB_FIFO_FWFT_EN
  logic [ADDR_W:0] ram_cnt;
`else
  logic            r_valid_q;
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    req       = '0;
    req.push  = w_en & ~full_q;
    req.pop   = r_en & ~empty_q;
    ram_rd_en = 1'b0;
    empty_d   = 1'b1;
    level_d   = level_q;

    unique case ({req.push, req.pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase

`ifdef IOB_FIFO_FWFT_EN
    // The port-B output latch is the head word; refill it when empty or being consumed.
    ram_cnt   = level_q - (empty_q ? '0 : LVL_ONE);
    ram_rd_en = (ram_cnt != '0) & (empty_q | req.pop);
    empty_d   = ~(ram_rd_en | (~empty_q & ~req.pop));
`else
    ram_rd_en = req.pop;
    empty_d   = (level_d == '0);
`endif

    wptr_d = req.push  ? wptr_q + PTR_ONE : wptr_q;
    rptr_d = ram_rd_en ? rptr_q + PTR_ONE : rptr_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      w_err_q <= 1'b0;
      r_err_q <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      full_q  <= (level_d == LVL_FULL);
      empty_q <= empty_d;
      w_err_q <= w_en & full_q;
      r_err_q <= r_en & empty_q;
    end
  end

`ifdef IOB_FIFO_FWFT_EN
  assign r_valid = ~empty_q;
`else
  always_ff @(posedge clk) begin
    if (!rst_n) r_valid_q <= 1'b0;
    else        r_valid_q <= req.pop;
  end
  assign r_valid = r_valid_q;
`endif

  iob_dp_ram_be #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk    (clk),
    .en_a   (req.push),
    .we_a   ({(DATA_W / 8){req.push}}),
    .addr_a (wptr_q),
    .din_a  (w_data),
    .dout_a (unused_dout_a),
    .en_b   (ram_rd_en),
    .we_b   ('0),
    .addr_b (rptr_q),
    .din_b  ('0),
    .dout_b (r_data)
  );

  assign w_full  = full_q;
  assign w_err   = w_err_q;
  assign r_empty = empty_q;
  assign r_err   = r_err_q;
  assign level   = level_q;

endmodule

// File: tb/tb_iob_fifo_sync.sv
// Scoreboard bench for iob_fifo_sync (DEPTH 4): a queue-based reference model pushes
// per-cycle expectations; a negedge monitor pops and compares them to the DUT outputs.
module tb_iob_fifo_sync;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 2;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk    = 1'b0;
  logic              rst_n  = 1'b0;
  logic              w_en   = 1'b0;
  logic              r_en   = 1'b0;
  logic [DATA_W-1:0] w_data = '0;
  logic              w_full, w_err, r_valid, r_empty, r_err;
  logic [DATA_W-1:0] r_data;
  logic [ADDR_W:0]   level;

  iob_fifo_sync #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .w_en    (w_en),
    .w_data  (w_data),
    .w_full  (w_full),
    .w_err   (w_err),
    .r_en    (r_en),
    .r_data  (r_data),
    .r_valid (r_valid),
    .r_empty (r_empty),
    .r_err   (r_err),
    .level   (level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                wr_edge;
  } word_t;

  typedef struct {
    logic              valid;
    logic [DATA_W-1:0] data;
    int                lvl;
    logic              full;
    logic              empty;
    logic              werr;
    logic              rerr;
  } exp_t;

  word_t model_q[$];
  exp_t  exp_q[$];
  int    n_edge    = 0;
  int    last_cons = 0;
  int    n_checks  = 0;
  int    n_pass    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

`ifdef IOB_FIFO_FWFT_EN
  // Head is visible one edge after its write, and no earlier than the edge that
  // consumed the previous head.
  function automatic logic head_visible(input int n);
    int t;
    if (model_q.size() == 0) return 1'b0;
    t = (model_q[0].wr_edge + 1 > last_cons) ? model_q[0].wr_edge + 1 : last_cons;
    return t <= n;
  endfunction
`endif

  task automatic step(input logic rst, input logic we, input logic [DATA_W-1:0] wd,
                      input logic re);
    exp_t  e;
    word_t w;
    logic  pop_ok, push_ok;
    rst_n  = rst;
    w_en   = we;
    w_data = wd;
    r_en   = re;
    @(posedge clk);
    n_edge++;
    e = '{valid: 1'b0, data: '0, lvl: 0, full: 1'b0, empty: 1'b1, werr: 1'b0, rerr: 1'b0};
    if (!rst) begin
      model_q.delete();
      last_cons = n_edge;
    end else begin
`ifdef IOB_FIFO_FWFT_EN
      pop_ok = re && head_visible(n_edge - 1);
`else
      pop_ok = re && (model_q.size() > 0);
`endif
      push_ok = we && (model_q.size() < DEPTH);
      w.data  = '0;
      if (pop_ok) begin
        w = model_q.pop_front();
        last_cons = n_edge;
      end
      if (push_ok) model_q.push_back('{data: wd, wr_edge: n_edge});
      e.lvl  = model_q.size();
      e.full = (model_q.size() == DEPTH);
      e.werr = we && !push_ok;
      e.rerr = re && !pop_ok;
`ifdef IOB_FIFO_FWFT_EN
      e.valid = head_visible(n_edge);
      e.data  = e.valid ? model_q[0].data : '0;
      e.empty = !e.valid;
`else
      e.valid = pop_ok;
      e.data  = w.data;
      e.empty = (model_q.size() == 0);
`endif
    end
    exp_q.push_back(e);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("r_valid", 64'(r_valid), 64'(e.valid));
      if (e.valid) check("r_data", 64'(r_data), 64'(e.data));
      check("level", 64'(level), 64'(e.lvl));
      check("w_full", 64'(w_full), 64'(e.full));
      check("r_empty", 64'(r_empty), 64'(e.empty));
      check("w_err", 64'(w_err), 64'(e.werr));
      check("r_err", 64'(r_err), 64'(e.rerr));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset, including a cycle where requests are present and must be ignored.
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);

    // In-order push then pop of four distinct words.
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, 32'(32'h1111_1111 * i), 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b0);

    // Overfill: fifth push rejected, then drain past empty.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, $urandom, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0, 1'b1);

    // Pop on empty, then push+pop on empty.
    step(1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b1, 32'hCAFE_0001, 1'b1);
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);

    // Fill to full, push+pop while full, then drain.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, $urandom, 1'b0);
    step(1'b1, 1'b1, 32'hBAD0_BAD0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, '0, 1'b1);

    // Ten fill/drain rounds to wrap both pointers repeatedly.
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, $urandom, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0, 1'b1);
      step(1'b1, 1'b0, '0, 1'b1);
    end

    // Mid-stream reset at level 3, then only new data comes back.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 32'(32'hAAAA_0000 + i), 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 32'h5555_0001, 1'b0);
    step(1'b1, 1'b1, 32'h5555_0002, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0, 1'b1);

    // Single word into empty, left idle, then a streamed burst.
    step(1'b1, 1'b1, 32'hA5A5_A5A5, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, $urandom, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0, 1'b1);

    // Random traffic with a shifting push/pop bias.
    for (int i = 0; i < 600; i++) begin
      logic we, re;
      we = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 65 : 35));
      re = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 35 : 65));
      step(1'b1, we, $urandom, re);
    end
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0, 1'b1);

    @(negedge clk);
    #1;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
